lights_out_solver: RTL

Hint engine for the DIP-switch Lights-Out stage. It runs the puzzle in reverse: given an LED pattern, it searches all 256 switch-toggle subsets for one whose combined XOR mask reproduces that pattern, so toggling those switches clears every LED. The stage controller drives it from the puzzle's current `led_out`. Its `hint_led` and `seg_data` outputs are multiplexed onto the board's LEDs and 7-segment display while a hint is requested.

---
 rtl/lights_out_solver.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/lights_out_solver.sv
// Lights-Out hint engine: exhaustively searches the 256 switch subsets for one whose XOR mask equals the LED pattern.
// Optional `LOS_MIN_WEIGHT_EN` scans all candidates and keeps the lowest-popcount solution instead of the first hit.
module lights_out_solver #(
   parameter logic [63:0] MASKS = 64'hA4D2EDB55AAD164B
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_i,
   input  logic        start_i,
   input  logic [7:0]  pattern_in_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        found_o,
   output logic [7:0]  solution_o,
   output logic [3:0]  weight_o,
   output logic [7:0]  hint_led_o,
   output logic [31:0] seg_data_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_RESULT = 2'd2
   } state_e;

   function automatic logic [7:0] mask_xor(input logic [7:0] sel);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (MASKS[8*i +: 8] & {8{sel[i]}});
      end
      return acc;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, v[i]};
      end
      return cnt;
   endfunction

   state_e      state_q, state_d;
   logic [7:0]  pat_q, pat_d;
   logic [7:0]  cand_q, cand_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        found_q, found_d;
   logic [7:0]  sol_q, sol_d;
   logic [3:0]  weight_q, weight_d;
   logic [7:0]  hint_q, hint_d;
   logic [31:0] seg_q, seg_d;

   logic        match;
   logic        last_cand;
   logic        accept;
   logic        term;
   logic [3:0]  cand_w;
   logic        res_found;
   logic [7:0]  res_c;
   logic [3:0]  res_w;

   // Candidate evaluation shared by both builds
   always_comb begin
      match     = (mask_xor(cand_q) == pat_q);
      cand_w    = popcount8(cand_q);
      last_cand = (cand_q == 8'hFF);
      accept    = enable_i && start_i && ((state_q == ST_IDLE) || (state_q == ST_RESULT));
   end

`ifdef LOS_MIN_WEIGHT_EN
   logic       any_q, any_d;
   logic [7:0] best_c_q, best_c_d;
   logic [3:0] best_w_q, best_w_d;
   logic       take_cur;

   // Best-so-far selection; strict less-than keeps the lower candidate on ties
   always_comb begin
      take_cur = match && (!any_q || (cand_w < best_w_q));
      term     = last_cand;
      res_found = any_q || match;
      if (take_cur) begin
         res_c = cand_q;
         res_w = cand_w;
      end else begin
         res_c = best_c_q;
         res_w = best_w_q;
      end
   end

   // Best-tracking next state
   always_comb begin
      any_d    = any_q;
      best_c_d = best_c_q;
      best_w_d = best_w_q;
      if (!enable_i || accept) begin
         any_d    = 1'b0;
         best_c_d = 8'h00;
         best_w_d = 4'd0;
      end else if ((state_q == ST_SEARCH) && take_cur) begin
         any_d    = 1'b1;
         best_c_d = cand_q;
         best_w_d = cand_w;
      end else begin
         any_d    = any_q;
      end
   end

   // Best-tracking registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_q    <= 1'b0;
         best_c_q <= 8'h00;
         best_w_q <= 4'd0;
      end else begin
         any_q    <= any_d;
         best_c_q <= best_c_d;
         best_w_q <= best_w_d;
      end
   end
`else
   // First hit wins, which is also the lowest candidate value
   always_comb begin
      term      = match || last_cand;
      res_found = match;
      res_c     = cand_q;
      res_w     = cand_w;
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!enable_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = start_i ? ST_SEARCH : ST_IDLE;
            ST_SEARCH: state_d = term ? ST_RESULT : ST_SEARCH;
            ST_RESULT: state_d = start_i ? ST_SEARCH : ST_RESULT;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath and registered-output next values
   always_comb begin
      pat_d    = pat_q;
      cand_d   = cand_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      found_d  = found_q;
      sol_d    = sol_q;
      weight_d = weight_q;
      hint_d   = hint_q;
      seg_d    = seg_q;
      if (!enable_i) begin
         pat_d    = 8'h00;
         cand_d   = 8'h00;
         busy_d   = 1'b0;
         found_d  = 1'b0;
         sol_d    = 8'h00;
         weight_d = 4'd0;
         hint_d   = 8'h00;
         seg_d    = 32'h0000_0000;
      end else if (accept) begin
         pat_d    = pattern_in_i;
         cand_d   = 8'h00;
         busy_d   = 1'b1;
         found_d  = 1'b0;
         sol_d    = 8'h00;
         weight_d = 4'd0;
         hint_d   = 8'h00;
         seg_d    = 32'h0000_0000;
      end else if (state_q == ST_SEARCH) begin
         if (term) begin
            busy_d   = 1'b0;
            done_d   = 1'b1;
            found_d  = res_found;
            sol_d    = res_found ? res_c : 8'h00;
            weight_d = res_found ? res_w : 4'd0;
            hint_d   = res_found ? res_c : 8'h00;
            seg_d    = res_found ? {16'h0000, 4'h0, res_w, res_c} : 32'h0000_EEEE;
         end else begin
            cand_d   = cand_q + 8'd1;
         end
      end else begin
         busy_d = busy_q;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q    <= 8'h00;
         cand_q   <= 8'h00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         sol_q    <= 8'h00;
         weight_q <= 4'd0;
         hint_q   <= 8'h00;
         seg_q    <= 32'h0000_0000;
      end else begin
         pat_q    <= pat_d;
         cand_q   <= cand_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         found_q  <= found_d;
         sol_q    <= sol_d;
         weight_q <= weight_d;
         hint_q   <= hint_d;
         seg_q    <= seg_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign found_o    = found_q;
   assign solution_o = sol_q;
   assign weight_o   = weight_q;
   assign hint_led_o = hint_q;
   assign seg_data_o = seg_q;

endmodule
